// File: rtl/dither_pkg.sv
// Shared types and helpers for the dither frame sequencer.
package dither_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_QUANT   = 3'd2,
    ST_DIFFUSE = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_FINISH  = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic fwd;
    logic below;
    logic below_fwd;
    logic below_back;
  } nb_flags_t;

  // "Forward" follows the scan direction of the current row; the row end is
  // the last pixel in that direction and the row start the first.
  function automatic nb_flags_t nb_calc(input int x, input int y, input logic dir_left,
                                        input int img_w, input int img_h);
    nb_flags_t f;
    logic row_end;
    logic row_start;
    logic has_below;
    row_end      = dir_left ? (x == 0) : (x == img_w - 1);
    row_start    = dir_left ? (x == img_w - 1) : (x == 0);
    has_below    = (y < img_h - 1);
    f.fwd        = !row_end;
    f.below      = has_below;
    f.below_fwd  = has_below && !row_end;
    f.below_back = has_below && !row_start;
    return f;
  endfunction

endpackage

// File: rtl/dither_scan_counter.sv
// Frame walk counters: channel, column, row and scan direction.
module dither_scan_counter
  import dither_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CHANNELS = 3,
  parameter int XW       = $clog2(IMG_W),
  parameter int YW       = $clog2(IMG_H),
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          serp_i,
  input  logic          step_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [CW-1:0] ch_o,
  output logic          dir_left_o,
  output logic          frame_end_o
);

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          dir_q, dir_d;
  logic          serp_q, serp_d;
  logic          row_end;

  assign row_end = dir_q ? (x_q == '0) : (x_q == X_LAST);

  // Next position: channel first, then column toward the row end, then row.
  // The caller never steps on the frame end, so y never passes Y_LAST.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    ch_d   = ch_q;
    dir_d  = dir_q;
    serp_d = serp_q;
    if (clr_i) begin
      x_d    = '0;
      y_d    = '0;
      ch_d   = '0;
      dir_d  = 1'b0;
      serp_d = serp_i;
    end else if (step_i) begin
      if (ch_q != CH_LAST) begin
        ch_d = ch_q + CW'(1);
      end else begin
        ch_d = '0;
        if (row_end) begin
          y_d = y_q + YW'(1);
          if (serp_q) dir_d = ~dir_q;
          else        x_d   = '0;
        end else if (dir_q) begin
          x_d = x_q - XW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      ch_q   <= '0;
      dir_q  <= 1'b0;
      serp_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      ch_q   <= ch_d;
      dir_q  <= dir_d;
      serp_q <= serp_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign ch_o        = ch_q;
  assign dir_left_o  = dir_q;
  assign frame_end_o = (ch_q == CH_LAST) && row_end && (y_q == Y_LAST);

endmodule

// File: rtl/dither_frame_sequencer.sv
// Frame sequencer for the error-diffusion dithering datapath.
//
// state      | meaning
// IDLE       | waiting for start
// LOAD       | old-pixel read requested, waiting for rd_valid
// QUANT      | one-cycle quantise/store strobe
// DIFFUSE    | error-diffusion writes requested, waiting for diff_ack
// ADVANCE    | step to the next component or leave for FINISH
// FINISH     | one-cycle done pulse, back to IDLE
module dither_frame_sequencer
  import dither_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CHANNELS = 3,
  parameter int XW       = $clog2(IMG_W),
  parameter int YW       = $clog2(IMG_H),
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          serpentine,
  input  logic          abort,
  output logic          rd_req,
  input  logic          rd_valid,
  output logic          quant_en,
  output logic          diff_req,
  input  logic          diff_ack,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] ch,
  output logic          dir_left,
  output logic          nb_fwd,
  output logic          nb_below,
  output logic          nb_below_fwd,
  output logic          nb_below_back,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  seq_state_e state_q, state_d;
  logic       aborted_q, aborted_d;
  logic       cnt_clr;
  logic       cnt_step;
  logic       frame_end;
  nb_flags_t  nb;

  dither_scan_counter #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .CHANNELS(CHANNELS),
    .XW      (XW),
    .YW      (YW),
    .CW      (CW)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .serp_i     (serpentine),
    .step_i     (cnt_step),
    .x_o        (x),
    .y_o        (y),
    .ch_o       (ch),
    .dir_left_o (dir_left),
    .frame_end_o(frame_end)
  );

  // Next state; abort overrides every handshake once a frame is running.
  always_comb begin
    state_d   = state_q;
    aborted_d = aborted_q;
    cnt_clr   = 1'b0;
    cnt_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          aborted_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD, ST_QUANT, ST_DIFFUSE, ST_ADVANCE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_FINISH;
        end else begin
          case (state_q)
            ST_LOAD:    if (rd_valid) state_d = ST_QUANT;
            ST_QUANT:   state_d = ST_DIFFUSE;
            ST_DIFFUSE: if (diff_ack) state_d = ST_ADVANCE;
            default: begin
              if (frame_end) begin
                state_d = ST_FINISH;
              end else begin
                cnt_step = 1'b1;
                state_d  = ST_LOAD;
              end
            end
          endcase
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and abort flag with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aborted_q <= aborted_d;
    end
  end

  assign rd_req   = (state_q == ST_LOAD);
  assign quant_en = (state_q == ST_QUANT);
  assign diff_req = (state_q == ST_DIFFUSE);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_QUANT) ||
                    (state_q == ST_DIFFUSE) || (state_q == ST_ADVANCE);
  assign done     = (state_q == ST_FINISH);
  assign aborted  = aborted_q;

  // Neighbour flags only mean something while a component is in flight.
  assign nb            = nb_calc(int'(x), int'(y), dir_left, IMG_W, IMG_H);
  assign nb_fwd        = busy && nb.fwd;
  assign nb_below      = busy && nb.below;
  assign nb_below_fwd  = busy && nb.below_fwd;
  assign nb_below_back = busy && nb.below_back;

endmodule
